// File: rtl/pio_cmd_pkg.sv
// Shared types and helpers for the PIO command handshake block.
package pio_cmd_pkg;

  // Handshake FSM states; RESYNC waits out a request level left high across reset
  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    ACK
  } state_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int ENTRY_W        = 2 * DEFAULT_DATA_W;

  // Ceiling log2, used to size FIFO pointers
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmd_sync_fifo.sv
// First-word-fall-through command FIFO; head entry is always visible on head_data.
module cmd_sync_fifo
  import pio_cmd_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  // Push is refused when full and pop is ignored when empty, so count never wraps
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & (count != '0);
    count_d = count;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; full is registered from the next count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pio_cmd_handshake.sv
// Four-phase request/acknowledge front end for the Nios II PIO command path.
module pio_cmd_handshake
  import pio_cmd_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_in,
  input  logic [DATA_W-1:0]   data_a,
  input  logic [DATA_W-1:0]   data_b,
  output logic                ack_out,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [2*DATA_W-1:0] cmd_data,
  output logic                fifo_full,
  output logic [CNT_W-1:0]    fifo_count
);

  state_t state_q;
  state_t state_d;
  logic   push;

  // State register; reset drops ack at once and forces a wait for req_in low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and push strobe; one push per request high phase, withheld while full
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      RESYNC: begin
        if (!req_in) state_d = IDLE;
      end
      IDLE: begin
        if (req_in && !fifo_full) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_in) state_d = IDLE;
      end
      default: state_d = RESYNC;
    endcase
  end

  assign ack_out   = (state_q == ACK);
  assign cmd_valid = (fifo_count != '0);

  cmd_sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({data_a, data_b}),
    .pop       (cmd_ready),
    .head_data (cmd_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_pio_cmd_handshake.sv
// Directed bench for pio_cmd_handshake: handshake, back-pressure, held request, reset, wrap.
module tb_pio_cmd_handshake;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  logic                clk       = 1'b0;
  logic                reset     = 1'b1;
  logic                req_in    = 1'b0;
  logic [DATA_W-1:0]   data_a    = '0;
  logic [DATA_W-1:0]   data_b    = '0;
  logic                cmd_ready = 1'b0;
  logic                ack_out;
  logic                cmd_valid;
  logic [2*DATA_W-1:0] cmd_data;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;

  int checks   = 0;
  int failures = 0;

  pio_cmd_handshake #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .data_a     (data_a),
    .data_b     (data_b),
    .ack_out    (ack_out),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [31:0] b);
    req_in = r;
    data_a = a;
    data_b = b;
  endtask

  task automatic doHandshake(input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, a, b);
    tick();
    checkOutput("hs_ack", ack_out, 1);
    applyStimulus(1'b0, a, b);
    tick();
    checkOutput("hs_release", ack_out, 0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) tick();

    // Reset state
    checkOutput("rst_ack", ack_out, 0);
    checkOutput("rst_valid", cmd_valid, 0);
    checkOutput("rst_data", cmd_data, 0);
    checkOutput("rst_full", fifo_full, 0);
    checkOutput("rst_count", fifo_count, 0);
    reset = 1'b0;
    tick();

    // Single request
    applyStimulus(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    checkOutput("single_ack", ack_out, 1);
    checkOutput("single_valid", cmd_valid, 1);
    checkOutput("single_data", cmd_data, 64'h1234_5678_9ABC_DEF0);
    checkOutput("single_count", fifo_count, 1);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("single_drop_ack", ack_out, 0);
    checkOutput("single_hold_count", fifo_count, 1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checkOutput("single_drain_count", fifo_count, 0);
    checkOutput("single_drain_valid", cmd_valid, 0);

    // Fill and back-pressure
    for (int i = 1; i <= 4; i++) doHandshake(32'(i), 32'(32'h100 + i));
    checkOutput("fill_count", fifo_count, 4);
    checkOutput("fill_full", fifo_full, 1);
    checkOutput("fill_head", cmd_data, {32'h1, 32'h101});
    applyStimulus(1'b1, 32'h5, 32'h105);
    tick();
    checkOutput("bp_ack0", ack_out, 0);
    tick();
    checkOutput("bp_ack1", ack_out, 0);
    checkOutput("bp_count", fifo_count, 4);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checkOutput("bp_pop_ack", ack_out, 0);
    checkOutput("bp_pop_count", fifo_count, 3);
    checkOutput("bp_pop_full", fifo_full, 0);
    checkOutput("bp_pop_head", cmd_data, {32'h2, 32'h102});
    tick();
    checkOutput("bp_push_ack", ack_out, 1);
    checkOutput("bp_push_count", fifo_count, 4);
    checkOutput("bp_push_full", fifo_full, 1);
    checkOutput("bp_push_head", cmd_data, {32'h2, 32'h102});
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("bp_release", ack_out, 0);
    cmd_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      checkOutput("bp_drain_valid", cmd_valid, 1);
      checkOutput("bp_drain_data", cmd_data, {32'(i), 32'(32'h100 + i)});
      tick();
    end
    cmd_ready = 1'b0;
    checkOutput("bp_drain_count", fifo_count, 0);

    // Held request gives exactly one push
    applyStimulus(1'b1, 32'hCAFE_0001, 32'hBEEF_0001);
    repeat (20) tick();
    checkOutput("held_ack", ack_out, 1);
    checkOutput("held_count", fifo_count, 1);
    checkOutput("held_data", cmd_data, 64'hCAFE_0001_BEEF_0001);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("held_release", ack_out, 0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checkOutput("held_drain", fifo_count, 0);

    // Concurrent push and pop
    doHandshake(32'h10, 32'h20);
    doHandshake(32'h11, 32'h21);
    checkOutput("cc_pre_count", fifo_count, 2);
    cmd_ready = 1'b1;
    applyStimulus(1'b1, 32'h12, 32'h22);
    tick();
    checkOutput("cc_ack", ack_out, 1);
    checkOutput("cc_count", fifo_count, 2);
    checkOutput("cc_head0", cmd_data, {32'h11, 32'h21});
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("cc_count1", fifo_count, 1);
    checkOutput("cc_head1", cmd_data, {32'h12, 32'h22});
    tick();
    checkOutput("cc_count0", fifo_count, 0);
    checkOutput("cc_valid0", cmd_valid, 0);
    cmd_ready = 1'b0;

    // Reset mid-handshake
    doHandshake(32'h20, 32'h30);
    doHandshake(32'h21, 32'h31);
    applyStimulus(1'b1, 32'h22, 32'h32);
    tick();
    checkOutput("mr_pre_ack", ack_out, 1);
    checkOutput("mr_pre_count", fifo_count, 3);
    #2 reset = 1'b1;
    #1;
    checkOutput("mr_ack", ack_out, 0);
    checkOutput("mr_count", fifo_count, 0);
    checkOutput("mr_valid", cmd_valid, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checkOutput("mr_resync_ack", ack_out, 0);
    checkOutput("mr_resync_count", fifo_count, 0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h33, 32'h44);
    tick();
    checkOutput("mr_new_ack", ack_out, 1);
    checkOutput("mr_new_count", fifo_count, 1);
    checkOutput("mr_new_data", cmd_data, {32'h33, 32'h44});
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    cmd_ready = 1'b1;
    tick();
    checkOutput("mr_drain", fifo_count, 0);

    // Wrap-around stream with the consumer always ready
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'(32'h200 + i), 32'(32'h300 + i));
      tick();
      checkOutput("wrap_ack", ack_out, 1);
      checkOutput("wrap_count1", fifo_count, 1);
      checkOutput("wrap_data", cmd_data, {32'(32'h200 + i), 32'(32'h300 + i)});
      applyStimulus(1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("wrap_count0", fifo_count, 0);
    end
    cmd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
